// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline control: stage indices,
// sequencer state encoding and the exception vector used by the PC mux.
package pipe_stage_ctrl_pkg;

  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;

  localparam int NUM_STG = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/pipe_stage_ctrl_sat_counter.sv
// Enable-driven up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!resetn) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: PC and stage-register
// write enables and clears, divider and data-memory waits, stall counter.
module pipe_stage_ctrl
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES  = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_id_load_use,
  input  logic                   i_ex_branch_taken,
  input  logic                   i_ex_div_start,
  input  logic                   i_mem_req,
  input  logic                   i_mem_ack,
  input  logic                   i_exc_valid,
  output logic                   o_pc_we,
  output logic [NUM_STG-1:0]     o_we,
  output logic [NUM_STG-1:0]     o_flush,
  output logic                   o_div_busy,
  output logic                   o_div_done,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

  state_e     state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;

  always_comb begin
    // Leaving MEM_WAIT is implied by any branch that does not re-enter a wait.
    state_d    = (state_q == MEM_WAIT) ? RUN : state_q;
    div_cnt_d  = div_cnt_q;
    o_pc_we    = 1'b1;
    o_we       = '1;
    o_flush    = '0;
    o_div_done = 1'b0;

    if (!resetn) begin
      state_d   = RUN;
      div_cnt_d = '0;
      o_pc_we   = 1'b0;
      o_we      = '0;
      o_flush   = '1;
    end else if ((state_q == MEM_WAIT) && !i_mem_ack) begin
      // An outstanding access cannot be cancelled, so exceptions wait for ack.
      state_d            = MEM_WAIT;
      o_pc_we            = 1'b0;
      o_we               = '0;
      o_we[STG_MEMWB]    = 1'b1;
      o_flush[STG_MEMWB] = 1'b1;
    end else if (i_exc_valid) begin
      state_d   = RUN;
      div_cnt_d = '0;
      o_flush   = '1;
    end else if (state_q == DIV_WAIT) begin
      if (div_cnt_q == 8'd0) begin
        state_d    = RUN;
        o_div_done = 1'b1;
      end else begin
        div_cnt_d          = div_cnt_q - 8'd1;
        o_pc_we            = 1'b0;
        o_we[STG_IFID]     = 1'b0;
        o_we[STG_IDEX]     = 1'b0;
        o_flush[STG_EXMEM] = 1'b1;
      end
    end else if (i_mem_req && !i_mem_ack) begin
      state_d            = MEM_WAIT;
      o_pc_we            = 1'b0;
      o_we               = '0;
      o_we[STG_MEMWB]    = 1'b1;
      o_flush[STG_MEMWB] = 1'b1;
    end else if (i_ex_div_start) begin
      state_d            = DIV_WAIT;
      div_cnt_d          = DIV_LOAD;
      o_pc_we            = 1'b0;
      o_we[STG_IFID]     = 1'b0;
      o_we[STG_IDEX]     = 1'b0;
      o_flush[STG_EXMEM] = 1'b1;
    end else if (i_ex_branch_taken) begin
      // Any load-use consumer in ID is on the wrong path, so branch wins.
      o_flush[STG_IFID] = 1'b1;
      o_flush[STG_IDEX] = 1'b1;
    end else if (i_id_load_use) begin
      o_pc_we           = 1'b0;
      o_we[STG_IFID]    = 1'b0;
      o_flush[STG_IDEX] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    div_cnt_q <= div_cnt_d;
  end

  assign o_div_busy = (state_q == DIV_WAIT);

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (~o_pc_we),
    .o_cnt  (o_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: a default build plus a 4-bit
// stall-counter build sharing the same stimulus.
module tb_pipe_stage_ctrl;

  logic        clk;
  logic        resetn;
  logic        i_id_load_use;
  logic        i_ex_branch_taken;
  logic        i_ex_div_start;
  logic        i_mem_req;
  logic        i_mem_ack;
  logic        i_exc_valid;

  logic        o_pc_we;
  logic [3:0]  o_we;
  logic [3:0]  o_flush;
  logic        o_div_busy;
  logic        o_div_done;
  logic [31:0] o_stall_cnt;

  logic        s_pc_we;
  logic [3:0]  s_we;
  logic [3:0]  s_flush;
  logic        s_div_busy;
  logic        s_div_done;
  logic [3:0]  s_stall_cnt;

  int ntests;
  int nfail;

  pipe_stage_ctrl #(
    .DIV_CYCLES  (32),
    .STALL_CNT_W (32)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .i_id_load_use     (i_id_load_use),
    .i_ex_branch_taken (i_ex_branch_taken),
    .i_ex_div_start    (i_ex_div_start),
    .i_mem_req         (i_mem_req),
    .i_mem_ack         (i_mem_ack),
    .i_exc_valid       (i_exc_valid),
    .o_pc_we           (o_pc_we),
    .o_we              (o_we),
    .o_flush           (o_flush),
    .o_div_busy        (o_div_busy),
    .o_div_done        (o_div_done),
    .o_stall_cnt       (o_stall_cnt)
  );

  pipe_stage_ctrl #(
    .DIV_CYCLES  (32),
    .STALL_CNT_W (4)
  ) dut_sat (
    .clk               (clk),
    .resetn            (resetn),
    .i_id_load_use     (i_id_load_use),
    .i_ex_branch_taken (i_ex_branch_taken),
    .i_ex_div_start    (i_ex_div_start),
    .i_mem_req         (i_mem_req),
    .i_mem_ack         (i_mem_ack),
    .i_exc_valid       (i_exc_valid),
    .o_pc_we           (s_pc_we),
    .o_we              (s_we),
    .o_flush           (s_flush),
    .o_div_busy        (s_div_busy),
    .o_div_done        (s_div_done),
    .o_stall_cnt       (s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_id_load_use     = 1'b0;
    i_ex_branch_taken = 1'b0;
    i_ex_div_start    = 1'b0;
    i_mem_req         = 1'b0;
    i_mem_ack         = 1'b0;
    i_exc_valid       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      ntests++;
      if ({o_pc_we, o_we, o_flush, o_div_done} !== {1'b0, 4'b0000, 4'b1111, 1'b0}) begin
        nfail++;
        $display("FAIL reset_outputs cyc=%0d got pc_we=%b we=%b flush=%b done=%b exp pc_we=0 we=0000 flush=1111 done=0",
                 c, o_pc_we, o_we, o_flush, o_div_done);
      end
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush} !== {1'b1, 4'b1111, 4'b0000}) begin
      nfail++;
      $display("FAIL reset_release got pc_we=%b we=%b flush=%b exp 1 1111 0000", o_pc_we, o_we, o_flush);
    end
    ntests++;
    if (o_stall_cnt !== 32'd0 || o_div_busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_cnt got stall_cnt=%0d busy=%b exp 0 0", o_stall_cnt, o_div_busy);
    end
  endtask

  task automatic test_div();
    do_reset();
    @(negedge clk);
    i_ex_div_start = 1'b1;
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush, o_div_busy} !== {1'b0, 4'b1100, 4'b0100, 1'b0}) begin
      nfail++;
      $display("FAIL div_start got pc_we=%b we=%b flush=%b busy=%b exp 0 1100 0100 0",
               o_pc_we, o_we, o_flush, o_div_busy);
    end
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      i_ex_div_start = 1'b0;
      #1;
      ntests++;
      if (o_div_busy !== 1'b1) begin
        nfail++;
        $display("FAIL div_busy k=%0d got %b exp 1", k, o_div_busy);
      end
      ntests++;
      if (k < 31) begin
        if ({o_pc_we, o_we, o_flush, o_div_done} !== {1'b0, 4'b1100, 4'b0100, 1'b0}) begin
          nfail++;
          $display("FAIL div_stall k=%0d got pc_we=%b we=%b flush=%b done=%b exp 0 1100 0100 0",
                   k, o_pc_we, o_we, o_flush, o_div_done);
        end
      end else begin
        if ({o_pc_we, o_we, o_flush, o_div_done} !== {1'b1, 4'b1111, 4'b0000, 1'b1}) begin
          nfail++;
          $display("FAIL div_done k=%0d got pc_we=%b we=%b flush=%b done=%b exp 1 1111 0000 1",
                   k, o_pc_we, o_we, o_flush, o_div_done);
        end
      end
    end
    @(negedge clk);
    #1;
    ntests++;
    if ({o_div_busy, o_div_done} !== 2'b00 || o_stall_cnt !== 32'd31) begin
      nfail++;
      $display("FAIL div_after got busy=%b done=%b stall_cnt=%0d exp 0 0 31",
               o_div_busy, o_div_done, o_stall_cnt);
    end
  endtask

  task automatic test_mem_exc();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      i_mem_req   = 1'b1;
      i_mem_ack   = (c == 5);
      i_exc_valid = (c >= 2);
      #1;
      ntests++;
      if (c < 5) begin
        if ({o_pc_we, o_we, o_flush} !== {1'b0, 4'b1000, 4'b1000}) begin
          nfail++;
          $display("FAIL mem_wait c=%0d got pc_we=%b we=%b flush=%b exp 0 1000 1000",
                   c, o_pc_we, o_we, o_flush);
        end
      end else begin
        if ({o_pc_we, o_we, o_flush} !== {1'b1, 4'b1111, 4'b1111}) begin
          nfail++;
          $display("FAIL mem_ack_exc got pc_we=%b we=%b flush=%b exp 1 1111 1111",
                   o_pc_we, o_we, o_flush);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush} !== {1'b1, 4'b1111, 4'b0000} || o_stall_cnt !== 32'd5) begin
      nfail++;
      $display("FAIL mem_after got pc_we=%b we=%b flush=%b stall_cnt=%0d exp 1 1111 0000 5",
               o_pc_we, o_we, o_flush, o_stall_cnt);
    end
  endtask

  task automatic test_lu_branch();
    do_reset();
    @(negedge clk);
    i_id_load_use     = 1'b1;
    i_ex_branch_taken = 1'b1;
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush} !== {1'b1, 4'b1111, 4'b0011}) begin
      nfail++;
      $display("FAIL lu_and_branch got pc_we=%b we=%b flush=%b exp 1 1111 0011", o_pc_we, o_we, o_flush);
    end
    @(negedge clk);
    i_ex_branch_taken = 1'b0;
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush} !== {1'b0, 4'b1110, 4'b0010}) begin
      nfail++;
      $display("FAIL load_use got pc_we=%b we=%b flush=%b exp 0 1110 0010", o_pc_we, o_we, o_flush);
    end
    @(negedge clk);
    i_id_load_use     = 1'b0;
    i_ex_branch_taken = 1'b1;
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush} !== {1'b1, 4'b1111, 4'b0011}) begin
      nfail++;
      $display("FAIL branch got pc_we=%b we=%b flush=%b exp 1 1111 0011", o_pc_we, o_we, o_flush);
    end
    @(negedge clk);
    idle_inputs();
    i_mem_req = 1'b1;
    i_mem_ack = 1'b1;
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush} !== {1'b1, 4'b1111, 4'b0000}) begin
      nfail++;
      $display("FAIL req_ack_hit got pc_we=%b we=%b flush=%b exp 1 1111 0000", o_pc_we, o_we, o_flush);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush, o_stall_cnt} !== {1'b1, 4'b1111, 4'b0000, 32'd1}) begin
      nfail++;
      $display("FAIL after_hit got pc_we=%b we=%b flush=%b stall_cnt=%0d exp 1 1111 0000 1",
               o_pc_we, o_we, o_flush, o_stall_cnt);
    end
    @(negedge clk);
    i_mem_req      = 1'b1;
    i_ex_div_start = 1'b1;
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush} !== {1'b0, 4'b1000, 4'b1000}) begin
      nfail++;
      $display("FAIL miss_beats_div got pc_we=%b we=%b flush=%b exp 0 1000 1000", o_pc_we, o_we, o_flush);
    end
    @(negedge clk);
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush, o_div_busy} !== {1'b0, 4'b1000, 4'b1000, 1'b0}) begin
      nfail++;
      $display("FAIL miss_hold_div got pc_we=%b we=%b flush=%b busy=%b exp 0 1000 1000 0",
               o_pc_we, o_we, o_flush, o_div_busy);
    end
  endtask

  task automatic test_div_exc();
    int ndone;
    do_reset();
    @(negedge clk);
    i_ex_div_start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      i_ex_div_start = 1'b0;
    end
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush, o_div_busy} !== {1'b0, 4'b1100, 4'b0100, 1'b1}) begin
      nfail++;
      $display("FAIL div_exc_pre got pc_we=%b we=%b flush=%b busy=%b exp 0 1100 0100 1",
               o_pc_we, o_we, o_flush, o_div_busy);
    end
    @(negedge clk);
    i_exc_valid = 1'b1;
    #1;
    ntests++;
    if ({o_pc_we, o_we, o_flush, o_div_done} !== {1'b1, 4'b1111, 4'b1111, 1'b0}) begin
      nfail++;
      $display("FAIL div_exc got pc_we=%b we=%b flush=%b done=%b exp 1 1111 1111 0",
               o_pc_we, o_we, o_flush, o_div_done);
    end
    @(negedge clk);
    i_exc_valid = 1'b0;
    #1;
    ntests++;
    if ({o_div_busy, o_pc_we, o_we, o_flush} !== {1'b0, 1'b1, 4'b1111, 4'b0000}) begin
      nfail++;
      $display("FAIL div_exc_after got busy=%b pc_we=%b we=%b flush=%b exp 0 1 1111 0000",
               o_div_busy, o_pc_we, o_we, o_flush);
    end
    ndone = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      #1;
      if (o_div_done === 1'b1) ndone++;
    end
    ntests++;
    if (ndone !== 0 || o_stall_cnt !== 32'd10) begin
      nfail++;
      $display("FAIL div_exc_nodone got done_pulses=%0d stall_cnt=%0d exp 0 10", ndone, o_stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    i_id_load_use = 1'b1;
    @(negedge clk);
    i_id_load_use = 1'b0;
    #1;
    ntests++;
    if (s_stall_cnt !== 4'd1 || o_stall_cnt !== 32'd1) begin
      nfail++;
      $display("FAIL sat_pre got narrow=%0d wide=%0d exp 1 1", s_stall_cnt, o_stall_cnt);
    end
    i_ex_div_start = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      i_ex_div_start = 1'b0;
    end
    #1;
    ntests++;
    if (s_stall_cnt !== 4'd15 || o_stall_cnt !== 32'd32) begin
      nfail++;
      $display("FAIL sat_hold got narrow=%0d wide=%0d exp 15 32", s_stall_cnt, o_stall_cnt);
    end
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    idle_inputs();
    resetn = 1'b0;
    test_reset();
    test_div();
    test_mem_exc();
    test_lu_branch();
    test_div_exc();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
